fetch_stage: RTL

Instruction fetch stage sitting directly upstream of the decoder. It owns the PC and issues word requests to instruction memory. Returned words are buffered in a small in-order FIFO and presented to the decoder as a registered instruction/PC pair. The stage honours the decoder's stall_if back-pressure and a branch redirect from execute; it flushes stale work and emits a NOP bubble whenever no valid instruction is available.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared constants for the fetch stage and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = INSTR_W;

  // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small in-order FIFO of {pc, instruction} entries; flush dominant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = cnt_width(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Storage needs no reset: nothing is read until the count says it is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC owner and instruction fetch front end feeding the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_if,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               inst_valid
);

  localparam int c_cnt_w = cnt_width(DEPTH);
  localparam int c_ent_w = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0]  c_word  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0]  c_align = ~ADDR_W'(3);
  localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(DEPTH);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic               r_valid;

  logic [ADDR_W-1:0]  w_target;
  logic [c_cnt_w:0]   w_used;
  logic               w_accept;
  logic [c_cnt_w-1:0] w_outstanding_next;
  logic               w_push;
  logic               w_pop;
  logic [c_ent_w-1:0] w_head;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic               w_fifo_empty;
  logic               w_fifo_full;

  assign w_target = branch_target & c_align;

  // Credits cover both words still owed by memory and words already buffered.
  assign w_used   = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req = !rst && !branch_valid && (w_used < c_depth);
  assign imem_addr = r_pc & c_align;
  assign w_accept = imem_req && imem_ready;

  assign w_outstanding_next = r_outstanding + c_cnt_w'(w_accept) - c_cnt_w'(imem_rvalid);

  // Requests are strictly sequential between redirects, so the PC of the next
  // kept response is simply a counter restarted at each branch target.
  assign w_push = imem_rvalid && !branch_valid && (r_drop == '0) && !w_fifo_full;
  assign w_pop  = !branch_valid && !stall_if && !w_fifo_empty;

  fetch_fifo #(
    .DATA_W (c_ent_w),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_valid),
    .push      (w_push),
    .push_data ({r_resp_pc, imem_rdata}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (branch_valid) begin
        r_pc      <= w_target;
        r_resp_pc <= w_target;
        r_drop    <= w_outstanding_next;
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + c_word;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + c_word;
        end
        if (imem_rvalid && (r_drop != '0)) begin
          r_drop <= r_drop - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr  <= NOP_INSTR;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else if (branch_valid) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!stall_if) begin
      if (!w_fifo_empty) begin
        r_instr  <= w_head[INSTR_W-1:0];
        r_pc_out <= w_head[c_ent_w-1 -: ADDR_W];
        r_valid  <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign instruction = r_instr;
  assign pc_out      = r_pc_out;
  assign inst_valid  = r_valid;

endmodule

`default_nettype wire
